// File: rtl/grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grf_write_arbiter
// Description : Owns the single GRF write port. WB has strict priority; MDU
//               results wait in a 1-entry hold register and commit in the
//               first cycle WB does not write. Keeps a pending-destination
//               scoreboard for in-flight MDU ops to drive the decode stall,
//               and asks for a WB bubble when a held result starves.
// Ports       : clk, reset (async, active-high)
//               wb_we/wb_wa/wb_wd/wb_pc          WB write request
//               mdu_issue/mdu_issue_rd           MDU op issued (sets pending)
//               mdu_valid/mdu_wa/mdu_wd/mdu_pc   MDU result, mdu_ready handshake
//               d_rs/d_rt -> stall               decode RAW check
//               freeze_req                       WB bubble request
//               grf_we/grf_wa/grf_wd/grf_pc      GRF write port (combinational)
// Config      : GRF_TRACE_EN - when defined, prints one trace line per
//               committed GRF write. Ports and timing are unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_write_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic [31:0] wb_pc,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_rd,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_wa,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  output logic        mdu_ready,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  output logic        stall,
  output logic        freeze_req,
  output logic        grf_we,
  output logic [4:0]  grf_wa,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_STARVE  = CNT_W'(STARVE_MAX);

  // Hold register
  logic        hold_full_q, hold_full_d;
  logic [4:0]  hold_wa_q,   hold_wa_d;
  logic [31:0] hold_wd_q,   hold_wd_d;
  logic [31:0] hold_pc_q,   hold_pc_d;

  // Scoreboard and starvation state
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             freeze_q,  freeze_d;

  // Combinational decisions
  logic        wb_req;
  logic        hold_sel;
  logic        hold_commit;
  logic        accept;
  logic [31:0] pend_set;
  logic [31:0] pend_clr;

  always_comb begin
    // Writes to $0 are not requests at all.
    wb_req      = wb_we && (wb_wa != 5'd0);
    // Hold drains whenever WB leaves the port free; a $0 entry drains silently.
    hold_sel    = !wb_req && hold_full_q;
    hold_commit = hold_sel && (hold_wa_q != 5'd0);
    // Only accept into an empty hold, so a new result never bypasses to the port.
    accept      = mdu_valid && !hold_full_q;
  end

  // Write port: driven straight from the arbitration, forced quiet in reset.
  always_comb begin
    grf_we = 1'b0;
    grf_wa = 5'd0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (!reset) begin
      if (wb_req) begin
        grf_we = 1'b1;
        grf_wa = wb_wa;
        grf_wd = wb_wd;
        grf_pc = wb_pc;
      end else if (hold_commit) begin
        grf_we = 1'b1;
        grf_wa = hold_wa_q;
        grf_wd = hold_wd_q;
        grf_pc = hold_pc_q;
      end
    end
  end

  // Next-state for hold register
  always_comb begin
    hold_full_d = hold_full_q;
    hold_wa_d   = hold_wa_q;
    hold_wd_d   = hold_wd_q;
    hold_pc_d   = hold_pc_q;
    if (hold_sel) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_wa_d   = mdu_wa;
      hold_wd_d   = mdu_wd;
      hold_pc_d   = mdu_pc;
    end
  end

  // Scoreboard: set is applied after clear so a same-cycle set wins.
  always_comb begin
    pend_set  = 32'd0;
    pend_clr  = 32'd0;
    if (mdu_issue && (mdu_issue_rd != 5'd0))
      pend_set = 32'd1 << mdu_issue_rd;
    if (hold_commit)
      pend_clr = 32'd1 << hold_wa_q;
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // Starvation counter: counts cycles the hold is full and WB takes the port.
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_full_q || hold_sel)
      cnt_d = '0;
    else if (cnt_q != C_CNT_MAX)
      cnt_d = cnt_q + 1'b1;
    // Looking at the next count makes freeze drop the cycle after the commit.
    freeze_d = (cnt_d >= C_STARVE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_wa_q   <= 5'd0;
      hold_wd_q   <= 32'd0;
      hold_pc_q   <= 32'd0;
      pending_q   <= 32'd0;
      cnt_q       <= '0;
      freeze_q    <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_wa_q   <= hold_wa_d;
      hold_wd_q   <= hold_wd_d;
      hold_pc_q   <= hold_pc_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      freeze_q    <= freeze_d;
    end
  end

  assign mdu_ready  = !hold_full_q;
  assign freeze_req = freeze_q;
  // Uses registered pending bits only: a commit this cycle does not unstall yet.
  assign stall = ((d_rs != 5'd0) && pending_q[d_rs]) ||
                 ((d_rt != 5'd0) && pending_q[d_rt]);

`ifdef GRF_TRACE_EN
  always @(posedge clk) begin
    if (!reset && grf_we)
      $display("%d@%h: $%d <= %h", $time, grf_pc, grf_wa, grf_wd);
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf_write_arbiter
// Description : Directed self-checking bench for grf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic [31:0] wb_pc;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_valid;
  logic [4:0]  mdu_wa;
  logic [31:0] mdu_wd;
  logic [31:0] mdu_pc;
  logic        mdu_ready;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic        stall;
  logic        freeze_req;
  logic        grf_we;
  logic [4:0]  grf_wa;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  int passed = 0;
  int total  = 0;

  grf_write_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .wb_pc(wb_pc),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .mdu_valid(mdu_valid), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .mdu_ready(mdu_ready), .d_rs(d_rs), .d_rt(d_rt), .stall(stall),
    .freeze_req(freeze_req), .grf_we(grf_we), .grf_wa(grf_wa),
    .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wb_we = 0; wb_wa = 0; wb_wd = 0; wb_pc = 0;
    mdu_issue = 0; mdu_issue_rd = 0;
    mdu_valid = 0; mdu_wa = 0; mdu_wd = 0; mdu_pc = 0;
    d_rs = 0; d_rt = 0;

    // Reset state
    tick(); tick();
    chk("rst_we", grf_we, 0);
    chk("rst_ready", mdu_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_freeze", freeze_req, 0);
    reset = 1'b0;
    tick();

    // WB and MDU in the same cycle: WB first, MDU one cycle later
    wb_we = 1; wb_wa = 5; wb_wd = 32'h11; wb_pc = 32'h100;
    mdu_valid = 1; mdu_wa = 6; mdu_wd = 32'h22; mdu_pc = 32'h200;
    #1;
    chk("c0_we", grf_we, 1);
    chk("c0_wa", grf_wa, 5);
    chk("c0_wd", grf_wd, 32'h11);
    chk("c0_pc", grf_pc, 32'h100);
    chk("c0_ready", mdu_ready, 1);
    tick();
    wb_we = 0; mdu_valid = 0;
    #1;
    chk("c1_we", grf_we, 1);
    chk("c1_wa", grf_wa, 6);
    chk("c1_wd", grf_wd, 32'h22);
    chk("c1_pc", grf_pc, 32'h200);
    chk("c1_ready", mdu_ready, 0);
    tick();
    chk("c2_ready", mdu_ready, 1);
    chk("c2_we", grf_we, 0);

    // Scoreboard stall on $8
    mdu_issue = 1; mdu_issue_rd = 8; d_rs = 8;
    #1;
    chk("s_same_cycle", stall, 0);
    tick();
    mdu_issue = 0;
    chk("s_next", stall, 1);
    tick(); tick();
    chk("s_hold", stall, 1);
    mdu_valid = 1; mdu_wa = 8; mdu_wd = 32'h88; mdu_pc = 32'h300;
    tick();
    mdu_valid = 0;
    #1;
    chk("s_commit_wa", grf_wa, 8);
    chk("s_commit_stall", stall, 1);
    tick();
    chk("s_after", stall, 0);
    d_rs = 0;

    // Same-cycle issue and commit of $9: set wins
    mdu_issue = 1; mdu_issue_rd = 9;
    tick();
    mdu_issue = 0;
    mdu_valid = 1; mdu_wa = 9; mdu_wd = 32'h99; mdu_pc = 32'h400;
    tick();
    mdu_valid = 0;
    mdu_issue = 1; mdu_issue_rd = 9; d_rt = 9;
    #1;
    chk("sw_commit_we", grf_we, 1);
    chk("sw_commit_wa", grf_wa, 9);
    tick();
    mdu_issue = 0;
    chk("sw_stall", stall, 1);
    mdu_valid = 1;
    tick();
    mdu_valid = 0;
    tick();
    chk("sw_clear", stall, 0);
    d_rt = 0;

    // Starvation: WB writes $3 every cycle while hold is full
    wb_we = 1; wb_wa = 3; wb_wd = 32'h33; wb_pc = 32'h500;
    mdu_valid = 1; mdu_wa = 10; mdu_wd = 32'hAA; mdu_pc = 32'h600;
    tick();
    mdu_valid = 0;
    chk("st_c1_freeze", freeze_req, 0);
    tick(); tick(); tick();
    chk("st_c4_freeze", freeze_req, 0);
    tick();
    chk("st_c5_freeze", freeze_req, 1);
    chk("st_c5_wa", grf_wa, 3);
    chk("st_c5_ready", mdu_ready, 0);
    wb_we = 0;
    #1;
    chk("st_bubble_wa", grf_wa, 10);
    chk("st_bubble_wd", grf_wd, 32'hAA);
    tick();
    chk("st_drop_freeze", freeze_req, 0);
    chk("st_drop_ready", mdu_ready, 1);

    // WB to $0 does not block the held MDU result
    mdu_valid = 1; mdu_wa = 12; mdu_wd = 32'hCC; mdu_pc = 32'h700;
    tick();
    mdu_valid = 0;
    wb_we = 1; wb_wa = 0; wb_wd = 32'hDEAD; wb_pc = 32'h800;
    #1;
    chk("z_we", grf_we, 1);
    chk("z_wa", grf_wa, 12);
    chk("z_wd", grf_wd, 32'hCC);
    tick();
    chk("z_wb0_we", grf_we, 0);
    wb_we = 0;

    // Held result to $0 is discarded without a write
    mdu_valid = 1; mdu_wa = 0; mdu_wd = 32'h55;
    tick();
    mdu_valid = 0;
    #1;
    chk("zd_we", grf_we, 0);
    chk("zd_ready", mdu_ready, 0);
    tick();
    chk("zd_ready_back", mdu_ready, 1);

    // Reset mid-cycle with the hold full
    wb_we = 1; wb_wa = 4; wb_wd = 32'h44;
    mdu_valid = 1; mdu_wa = 7; mdu_wd = 32'h77; mdu_pc = 32'h900;
    tick();
    mdu_valid = 0; wb_we = 0;
    #1;
    chk("r_pre_wa", grf_wa, 7);
    #2;
    reset = 1'b1;
    #1;
    chk("r_we", grf_we, 0);
    chk("r_wa", grf_wa, 0);
    chk("r_wd", grf_wd, 0);
    chk("r_ready", mdu_ready, 1);
    tick();
    reset = 1'b0;
    #1;
    chk("r_after_we", grf_we, 0);
    tick();
    chk("r_after2_we", grf_we, 0);
    chk("r_after_ready", mdu_ready, 1);
    chk("r_after_freeze", freeze_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
